// File: rtl/bram_access_arbiter_pkg.sv
// Shared types for the BRAM access arbiter: controller states, requester id
// and the registered read-response tag.
package bram_access_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    typedef logic req_id_t;

    // Read request as seen by one requester (address width fixed at the widest supported)
    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
    } rd_req_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_req_t;

    // Response qualifier that travels one cycle behind the read grant
    typedef struct packed {
        logic    vld;
        req_id_t tag;
    } rsp_tag_t;

    function automatic req_id_t grant_to_id(input logic [1:0] grant);
        return grant[1];
    endfunction

endpackage

// File: rtl/bram_access_arbiter_if.sv
// Bundle of requester read/write handshakes, clear control and the BRAM port.
interface bram_access_arbiter_if #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDRESS_WIDTH = 11
);
    logic                     rd_valid_0, rd_valid_1;
    logic [ADDRESS_WIDTH-1:0] rd_addr_0, rd_addr_1;
    logic                     rd_ready_0, rd_ready_1;
    logic                     rsp_valid_0, rsp_valid_1;
    logic [DATA_WIDTH-1:0]    rsp_data;

    logic                     wr_valid_0, wr_valid_1;
    logic [ADDRESS_WIDTH-1:0] wr_addr_0, wr_addr_1;
    logic [DATA_WIDTH-1:0]    wr_data_0, wr_data_1;
    logic                     wr_ready_0, wr_ready_1;

    logic                     clear_start, clear_busy, clear_done;

    logic [ADDRESS_WIDTH-1:0] bram_raddr;
    logic [DATA_WIDTH-1:0]    bram_dout;
    logic                     bram_wen;
    logic [ADDRESS_WIDTH-1:0] bram_waddr;
    logic [DATA_WIDTH-1:0]    bram_din;

    modport slave (
        input  rd_valid_0, rd_valid_1, rd_addr_0, rd_addr_1,
        output rd_ready_0, rd_ready_1, rsp_valid_0, rsp_valid_1, rsp_data,
        input  wr_valid_0, wr_valid_1, wr_addr_0, wr_addr_1, wr_data_0, wr_data_1,
        output wr_ready_0, wr_ready_1,
        input  clear_start,
        output clear_busy, clear_done,
        output bram_raddr, bram_wen, bram_waddr, bram_din,
        input  bram_dout
    );

    modport master (
        output rd_valid_0, rd_valid_1, rd_addr_0, rd_addr_1,
        input  rd_ready_0, rd_ready_1, rsp_valid_0, rsp_valid_1, rsp_data,
        output wr_valid_0, wr_valid_1, wr_addr_0, wr_addr_1, wr_data_0, wr_data_1,
        input  wr_ready_0, wr_ready_1,
        output clear_start,
        input  clear_busy, clear_done,
        input  bram_raddr, bram_wen, bram_waddr, bram_din,
        output bram_dout
    );
endinterface

// File: rtl/bram_access_arbiter_rr_arbiter2.sv
// Two-input round-robin arbiter; priority passes to the other requester
// whenever a grant is issued.
module rr_arbiter2 (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] valid,
    output logic [1:0] grant
);
    logic pri_p0;  // requester currently holding priority

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            if (valid == 2'b11) grant[pri_p0] = 1'b1;
            else                grant = valid;
        end
    end

    always_ff @(posedge clock) begin
        if (reset)       pri_p0 <= 1'b0;
        else if (|grant) pri_p0 <= grant[0];
    end
endmodule

// File: rtl/bram_access_arbiter.sv
// Arbitrates two requesters onto a simple-dual-port BRAM with independent
// read/write round-robin and a sequencer that zeroes the whole array.
module bram_access_arbiter
    import bram_access_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDRESS_WIDTH = 11
) (
    input logic                   clock,
    input logic                   reset,
    bram_access_arbiter_if.slave  bus
);
    state_t                   state;
    logic [ADDRESS_WIDTH-1:0] clear_cnt;
    logic                     clear_done_p0;
    rsp_tag_t                 rsp_p0;
    logic [ADDRESS_WIDTH-1:0] raddr_last_p0;

    logic                     idle_active;
    logic [1:0]               rd_grant, wr_grant;
    logic [ADDRESS_WIDTH-1:0] rd_addr_sel, wr_addr_sel;
    logic [DATA_WIDTH-1:0]    wr_data_sel;

    // Reset gates every grant and write so nothing reaches the BRAM on the reset edge
    assign idle_active = (state == IDLE) && !reset;

    rr_arbiter2 u_rd_arb (
        .clock  (clock),
        .reset  (reset),
        .enable (idle_active),
        .valid  ({bus.rd_valid_1, bus.rd_valid_0}),
        .grant  (rd_grant)
    );

    rr_arbiter2 u_wr_arb (
        .clock  (clock),
        .reset  (reset),
        .enable (idle_active),
        .valid  ({bus.wr_valid_1, bus.wr_valid_0}),
        .grant  (wr_grant)
    );

    assign bus.rd_ready_0 = rd_grant[0];
    assign bus.rd_ready_1 = rd_grant[1];
    assign bus.wr_ready_0 = wr_grant[0];
    assign bus.wr_ready_1 = wr_grant[1];

    assign rd_addr_sel = rd_grant[1] ? bus.rd_addr_1 : bus.rd_addr_0;
    assign wr_addr_sel = wr_grant[1] ? bus.wr_addr_1 : bus.wr_addr_0;
    assign wr_data_sel = wr_grant[1] ? bus.wr_data_1 : bus.wr_data_0;

    assign bus.bram_raddr = (|rd_grant) ? rd_addr_sel : raddr_last_p0;

    always_comb begin
        bus.bram_wen   = 1'b0;
        bus.bram_waddr = '0;
        bus.bram_din   = '0;
        if (state == CLEAR && !reset) begin
            bus.bram_wen   = 1'b1;
            bus.bram_waddr = clear_cnt;
        end else if (|wr_grant) begin
            bus.bram_wen   = 1'b1;
            bus.bram_waddr = wr_addr_sel;
            bus.bram_din   = wr_data_sel;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            clear_cnt     <= '0;
            clear_done_p0 <= 1'b0;
        end else begin
            clear_done_p0 <= 1'b0;
            case (state)
                IDLE: if (bus.clear_start) state <= CLEAR;
                CLEAR: begin
                    clear_cnt <= clear_cnt + 1'b1;
                    if (clear_cnt == '1) begin
                        state         <= IDLE;
                        clear_done_p0 <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ---- p0: read grant registered alongside the BRAM's own output register
    always_ff @(posedge clock) begin
        if (reset) begin
            rsp_p0        <= '0;
            raddr_last_p0 <= '0;
        end else begin
            rsp_p0.vld <= |rd_grant;
            rsp_p0.tag <= grant_to_id(rd_grant);
            if (|rd_grant) raddr_last_p0 <= rd_addr_sel;
        end
    end

    assign bus.rsp_valid_0 = rsp_p0.vld && (rsp_p0.tag == 1'b0);
    assign bus.rsp_valid_1 = rsp_p0.vld && (rsp_p0.tag == 1'b1);
    assign bus.rsp_data    = bus.bram_dout;
    assign bus.clear_busy  = (state == CLEAR);
    assign bus.clear_done  = clear_done_p0;
endmodule
